// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ write-back sources.
// Optional macro REG0_WRITE_BLOCK_EN: grants to address 0 handshake but never assert reg_wr.
module reg_wb_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 5,
    parameter  int DATA_W  = 32,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_stall,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      reg_wr,
    output logic [ADDR_W-1:0]         reg_write_addr,
    output logic [DATA_W-1:0]         reg_din,
    output logic [GW-1:0]             grant_id,
    output logic [15:0]               grant_cnt
);

    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     lo_idx;
    logic [GW-1:0]     hi_idx;
    logic              any_lo;
    logic              any_hi;
    logic              grant_en;
    logic              write_ok;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    // Rotating priority as two scans: first valid at/above rr_ptr, else first valid overall.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        any_lo = 1'b0;
        any_hi = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !any_lo) begin
                lo_idx = GW'(i);
                any_lo = 1'b1;
            end
            if (req_valid[i] && !any_hi && (i >= 32'(rr_ptr))) begin
                hi_idx = GW'(i);
                any_hi = 1'b1;
            end
        end
        winner   = any_hi ? hi_idx : lo_idx;
        grant_en = any_lo && !wb_stall && rst_n;
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == winner) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = grant_en ? (NUM_REQ'(1) << winner) : '0;

`ifdef REG0_WRITE_BLOCK_EN
    assign write_ok = (win_addr != '0);
`else
    assign write_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            reg_wr         <= 1'b0;
            reg_write_addr <= '0;
            reg_din        <= '0;
            grant_id       <= '0;
            grant_cnt      <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (grant_en) begin
                rr_ptr <= (winner == GW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                if (grant_cnt != 16'hFFFF)
                    grant_cnt <= grant_cnt + 16'd1;
                if (write_ok) begin
                    reg_wr         <= 1'b1;
                    reg_write_addr <= win_addr;
                    reg_din        <= win_data;
                    grant_id       <= winner;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter (NUM_REQ=4) against a scan-order reference model.
module tb_reg_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_stall;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            reg_wr;
    logic [AW-1:0]   reg_write_addr;
    logic [DW-1:0]   reg_din;
    logic [1:0]      grant_id;
    logic [15:0]     grant_cnt;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] a_addr [N];
    logic [DW-1:0] a_data [N];
    logic [DW-1:0] dut_rf [32];

    int          m_ptr;
    logic        m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_din;
    logic [1:0]  m_gid;
    logic [15:0] m_cnt;

    reg_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_stall       (wb_stall),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .reg_wr         (reg_wr),
        .reg_write_addr (reg_write_addr),
        .reg_din        (reg_din),
        .grant_id       (grant_id),
        .grant_cnt      (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_addr[i];
            req_data[i*DW +: DW] = a_data[i];
        end
    endtask

    // Winner is the first valid requester visiting m_ptr, m_ptr+1, ... modulo N.
    function automatic logic [N-1:0] exp_ready();
        int idx;
        if (!rst_n || wb_stall) return '0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    task automatic model_edge();
        logic [N-1:0] r;
        int k;
        logic blocked;
        r = exp_ready();
        if (!rst_n) begin
            m_ptr = 0; m_wr = 0; m_addr = 0; m_din = 0; m_gid = 0; m_cnt = 0;
        end else if (r != 0) begin
            k = 0;
            for (int i = 0; i < N; i++) if (r[i]) k = i;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            m_ptr = (k + 1) % N;
            blocked = 1'b0;
`ifdef REG0_WRITE_BLOCK_EN
            blocked = (a_addr[k] == 0);
`endif
            if (blocked) m_wr = 0;
            else begin
                m_wr = 1; m_addr = a_addr[k]; m_din = a_data[k]; m_gid = 2'(k);
            end
        end else begin
            m_wr = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (reg_wr) dut_rf[reg_write_addr] = reg_din;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; wb_stall = 0; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin a_addr[i] = 5'(i + 8); a_data[i] = 32'(i * 3 + 1); end
        pack();
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
            tick();
        end
        rst_n = 1; req_valid = 0; #1;
        total++;
        if (reg_wr !== 1'b0 || grant_cnt !== 16'd0 || grant_id !== 2'd0 || reg_write_addr !== 5'd0 || reg_din !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got wr=%b cnt=%0d gid=%0d addr=%0d din=%h exp all 0", reg_wr, grant_cnt, grant_id, reg_write_addr, reg_din);
        end
        req_valid = 4'b1111; #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", req_ready); end
        tick();
        total++;
        if (reg_wr !== 1'b1 || grant_id !== 2'd0 || reg_write_addr !== 5'd8 || grant_cnt !== 16'd1) begin
            bad++;
            $display("FAIL first_write got wr=%b gid=%0d addr=%0d cnt=%0d exp 1/0/8/1", reg_wr, grant_id, reg_write_addr, grant_cnt);
        end
        req_valid = 0;
    endtask

    task automatic test_single();
        a_addr[2] = 5'd2; a_data[2] = 32'h000000F0; pack();
        req_valid = 4'b0100; #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = 0;
        total++;
        if (reg_wr !== 1'b1 || reg_write_addr !== 5'd2 || reg_din !== 32'h000000F0 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL single_write got wr=%b addr=%0d din=%h gid=%0d exp 1/2/000000f0/2", reg_wr, reg_write_addr, reg_din, grant_id);
        end
        tick();
        total++;
        if (reg_wr !== 1'b0 || reg_write_addr !== 5'd2 || reg_din !== 32'h000000F0 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL idle_hold got wr=%b addr=%0d din=%h gid=%0d exp 0/2/000000f0/2", reg_wr, reg_write_addr, reg_din, grant_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin a_addr[i] = 5'($urandom_range(1, 31)); a_data[i] = $urandom; end
            pack(); #1;
            total++;
            if (req_ready !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
            tick();
            total++;
            if (reg_wr !== 1'b1 || grant_id !== 2'(c % 4) || reg_din !== m_din || reg_write_addr !== m_addr) begin
                bad++;
                $display("FAIL rr_write c=%0d got wr=%b gid=%0d din=%h addr=%0d exp 1/%0d/%h/%0d", c, reg_wr, grant_id, reg_din, reg_write_addr, c % 4, m_din, m_addr);
            end
        end
        req_valid = 0;
        total++;
        if (grant_cnt !== 16'd8) begin bad++; $display("FAIL rr_count got=%0d exp=8", grant_cnt); end
    endtask

    task automatic test_stall();
        tick();
        req_valid = 4'b1010; wb_stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin bad++; $display("FAIL stall_ready c=%0d got=%b exp=0000", c, req_ready); end
            tick();
            total++;
            if (reg_wr !== 1'b0 || grant_cnt !== 16'd8) begin bad++; $display("FAIL stall_wr c=%0d got wr=%b cnt=%0d exp 0/8", c, reg_wr, grant_cnt); end
        end
        wb_stall = 0; #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_rel1 got=%b exp=0010", req_ready); end
        tick();
        req_valid = 4'b1000; #1;
        total++;
        if (req_ready !== 4'b1000 || reg_wr !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL stall_rel2 got ready=%b wr=%b gid=%0d exp 1000/1/1", req_ready, reg_wr, grant_id);
        end
        tick();
        req_valid = 0;
        total++;
        if (reg_wr !== 1'b1 || grant_id !== 2'd3) begin bad++; $display("FAIL stall_rel3 got wr=%b gid=%0d exp 1/3", reg_wr, grant_id); end
        tick();
    endtask

    task automatic test_same_addr();
        do_reset();
        a_addr[0] = 5'd4; a_data[0] = 32'h0F;
        a_addr[1] = 5'd4; a_data[1] = 32'hAA;
        pack();
        req_valid = 4'b0011; #1;
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL same_ready0 got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        total++;
        if (reg_wr !== 1'b1 || reg_write_addr !== 5'd4 || reg_din !== 32'h0F) begin
            bad++;
            $display("FAIL same_first got wr=%b addr=%0d din=%h exp 1/4/0000000f", reg_wr, reg_write_addr, reg_din);
        end
        tick();
        req_valid = 0;
        total++;
        if (reg_wr !== 1'b1 || reg_write_addr !== 5'd4 || reg_din !== 32'hAA) begin
            bad++;
            $display("FAIL same_second got wr=%b addr=%0d din=%h exp 1/4/000000aa", reg_wr, reg_write_addr, reg_din);
        end
        tick();
        total++;
        if (dut_rf[4] !== 32'hAA) begin bad++; $display("FAIL same_final got=%h exp=000000aa", dut_rf[4]); end
    endtask

    task automatic test_reg0();
        logic [15:0] cnt0;
        logic        exp_wr;
        cnt0 = grant_cnt;
`ifdef REG0_WRITE_BLOCK_EN
        exp_wr = 1'b0;
`else
        exp_wr = 1'b1;
`endif
        a_addr[2] = 5'd0; a_data[2] = 32'hFFFF; pack();
        req_valid = 4'b0100; #1;
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL reg0_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = 0;
        total++;
        if (reg_wr !== exp_wr || grant_cnt !== cnt0 + 16'd1) begin
            bad++;
            $display("FAIL reg0_write got wr=%b cnt=%0d exp %b/%0d", reg_wr, grant_cnt, exp_wr, cnt0 + 16'd1);
        end
        if (exp_wr) begin
            total++;
            if (reg_write_addr !== 5'd0 || reg_din !== 32'hFFFF) begin
                bad++;
                $display("FAIL reg0_data got addr=%0d din=%h exp 0/0000ffff", reg_write_addr, reg_din);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        a_addr[0] = 5'd9; pack();
        req_valid = 4'b0001; tick();
        rst_n = 0; #1;
        total++;
        if (req_ready !== 4'b0000 || reg_wr !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready got ready=%b wr=%b exp 0000/1", req_ready, reg_wr);
        end
        tick();
        total++;
        if (reg_wr !== 1'b0 || grant_cnt !== 16'd0) begin bad++; $display("FAIL midrst_wr got wr=%b cnt=%0d exp 0/0", reg_wr, grant_cnt); end
        rst_n = 1; req_valid = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] r;
        int           waits [N];
        pend = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    a_addr[i] = 5'($urandom_range(0, 31));
                    a_data[i] = $urandom;
                end
            end
            pack();
            req_valid = pend;
            wb_stall  = ($urandom_range(0, 5) == 0);
            rst_n     = ($urandom_range(0, 60) != 0);
            #1;
            r = exp_ready();
            total++;
            if (req_ready !== r) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, r); end
            if (!rst_n) begin
                for (int i = 0; i < N; i++) waits[i] = 0;
            end else if (r != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (r[i]) begin
                        waits[i] = 0;
                    end else if (pend[i]) begin
                        waits[i]++;
                        total++;
                        if (waits[i] >= N) begin bad++; $display("FAIL rand_fair req=%0d got waits=%0d exp <%0d", i, waits[i], N); end
                    end
                end
            end
            tick();
            pend = pend & ~r;
            total++;
            if (reg_wr !== m_wr || reg_write_addr !== m_addr || reg_din !== m_din || grant_id !== m_gid || grant_cnt !== m_cnt) begin
                bad++;
                $display("FAIL rand_out c=%0d got wr=%b addr=%0d din=%h gid=%0d cnt=%0d exp %b/%0d/%h/%0d/%0d",
                         c, reg_wr, reg_write_addr, reg_din, grant_id, grant_cnt, m_wr, m_addr, m_din, m_gid, m_cnt);
            end
        end
        rst_n = 1; wb_stall = 0; req_valid = 0;
    endtask

    initial begin
        rst_n = 0; wb_stall = 0; req_valid = 0; req_addr = '0; req_data = '0;
        m_ptr = 0; m_wr = 0; m_addr = 0; m_din = 0; m_gid = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_same_addr();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
